// File: rtl/s_p_ram_arbiter_pkg.sv
// s_p_ram_arbiter_pkg: shared widths, FSM encodings and op/grant codes for the RAM arbiter.
package s_p_ram_arbiter_pkg;
    localparam int P_ADDR  = 3;
    localparam int P_WIDTH = 16;
    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;
endpackage

// File: rtl/s_p_ram_arbiter_if.sv
// s_p_ram_arbiter_if: one requester's handshake onto the RAM arbiter.
interface s_p_ram_arbiter_if #(
    parameter int ADDR  = 3,
    parameter int WIDTH = 16
);
    logic             req;
    logic             wr;
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] wdata;
    logic             ack;
    logic [WIDTH-1:0] rdata;
    modport master (output req, wr, addr, wdata, input ack, rdata);
    modport slave  (input req, wr, addr, wdata, output ack, rdata);
endinterface

// File: rtl/s_p_ram_arbiter_rr_arb2.sv
// s_p_ram_arbiter_rr_arb2: combinational 2-way round-robin picker; bit 0 is A, bit 1 is B.
module s_p_ram_arbiter_rr_arb2
    import s_p_ram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       any_o
);
    assign any_o   = |req_i;
    assign grant_o = &req_i ? ~last_grant_i : (req_i[1] ? GNT_B : GNT_A);
endmodule

// File: rtl/s_p_ram_arbiter.sv
// s_p_ram_arbiter: serialises requesters A and B onto an async single-port RAM
// as setup -> strobe -> hold, and owns the RAM clear strobe.
module s_p_ram_arbiter
    import s_p_ram_arbiter_pkg::*;
#(
    parameter int ADDR  = P_ADDR,
    parameter int WIDTH = P_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    s_p_ram_arbiter_if.slave a_if,
    s_p_ram_arbiter_if.slave b_if,
    output logic             ram_rst_o,
    output logic             ram_we_o,
    output logic             ram_re_o,
    output logic [ADDR-1:0]  ram_addr_o,
    inout  wire  [WIDTH-1:0] ram_data_io
);
    logic [2:0]       state_q, state_d;
    logic             op_q, gnt_q, grant, any, drive;
    logic [ADDR-1:0]  addr_q;
    logic [WIDTH-1:0] wdata_q, a_rdata_q, b_rdata_q;

    s_p_ram_arbiter_rr_arb2 u_rr (
        .req_i        ({b_if.req, a_if.req}),
        .last_grant_i (gnt_q),
        .grant_o      (grant),
        .any_o        (any)
    );

    assign state_d = state_q == S_INIT   ? S_IDLE :
                     state_q == S_IDLE   ? (any ? S_SETUP : S_IDLE) :
                     state_q == S_SETUP  ? S_STROBE :
                     state_q == S_STROBE ? S_HOLD : S_IDLE;

    // gnt_q doubles as last_grant: it is only rewritten at the next grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_INIT;
            op_q      <= OP_RD;
            gnt_q     <= GNT_B;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && any) begin
                gnt_q   <= grant;
                op_q    <= grant == GNT_B ? b_if.wr : a_if.wr;
                addr_q  <= grant == GNT_B ? b_if.addr : a_if.addr;
                wdata_q <= grant == GNT_B ? b_if.wdata : a_if.wdata;
            end
            if (state_q == S_STROBE && op_q == OP_RD && gnt_q == GNT_A) a_rdata_q <= ram_data_io;
            if (state_q == S_STROBE && op_q == OP_RD && gnt_q == GNT_B) b_rdata_q <= ram_data_io;
        end
    end

    assign drive       = op_q == OP_WR && (state_q == S_SETUP || state_q == S_STROBE || state_q == S_HOLD);
    assign ram_data_io = drive ? wdata_q : {WIDTH{1'bz}};
    assign ram_rst_o   = state_q == S_INIT;
    assign ram_we_o    = state_q == S_STROBE && op_q == OP_WR;
    assign ram_re_o    = state_q == S_STROBE && op_q == OP_RD;
    assign ram_addr_o  = addr_q;
    assign a_if.ack    = state_q == S_HOLD && gnt_q == GNT_A;
    assign b_if.ack    = state_q == S_HOLD && gnt_q == GNT_B;
    assign a_if.rdata  = a_rdata_q;
    assign b_if.rdata  = b_rdata_q;
endmodule

// File: tb/tb_s_p_ram_arbiter.sv
// tb_s_p_ram_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbiter and a behavioural RAM.
module tb_s_p_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_rst, ram_we, ram_re;
    logic [2:0] ram_addr;
    wire  [15:0] ram_data;
    int checks = 0, failures = 0, n_acks = 0, n_grants = 0;

    s_p_ram_arbiter_if #(.ADDR(3), .WIDTH(16)) a_if ();
    s_p_ram_arbiter_if #(.ADDR(3), .WIDTH(16)) b_if ();

    s_p_ram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .a_if        (a_if),
        .b_if        (b_if),
        .ram_rst_o   (ram_rst),
        .ram_we_o    (ram_we),
        .ram_re_o    (ram_re),
        .ram_addr_o  (ram_addr),
        .ram_data_io (ram_data)
    );

    always #5 clk = ~clk;

    // behavioural RAM: cleared while ram_rst, writes committed at the end of the we strobe
    logic [15:0] mem [8];
    always @(posedge clk) begin
        if (ram_rst) for (int i = 0; i < 8; i++) mem[i] <= '0;
        else if (ram_we) mem[ram_addr] <= ram_data;
    end
    assign ram_data = ram_re ? mem[ram_addr] : 'z;

    // transaction model: one access occupies the three cycles after its grant edge
    bit          m_init, m_active, m_who, m_last, m_wr;
    int          m_off;
    logic [2:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] ref_mem [8];
    logic [15:0] ref_rd [2];
    wire exp_drive = !rst && m_active && m_wr;
    wire keep_en   = !exp_drive && !ram_re;
    // keeper drives 0 whenever the bus should be free, so a stray DUT driver shows up
    assign ram_data = keep_en ? 16'h0000 : 'z;

    function automatic bit pick(input bit a, input bit b, input bit last);
        return (a && b) ? !last : b;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_init   <= 1'b1;
            m_active <= 1'b0;
            m_off    <= 0;
            m_last   <= 1'b1;
            m_who    <= 1'b0;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            ref_rd[0] <= '0;
            ref_rd[1] <= '0;
            for (int i = 0; i < 8; i++) ref_mem[i] <= '0;
        end else if (m_init) begin
            m_init <= 1'b0;
        end else if (m_active) begin
            m_off <= m_off + 1;
            if (m_off == 1 && m_wr) ref_mem[m_addr] <= m_wdata;
            if (m_off == 1 && !m_wr) ref_rd[m_who] <= ref_mem[m_addr];
            if (m_off == 2) m_active <= 1'b0;
        end else if (a_if.req || b_if.req) begin
            m_who    <= pick(a_if.req, b_if.req, m_last);
            m_last   <= pick(a_if.req, b_if.req, m_last);
            m_wr     <= pick(a_if.req, b_if.req, m_last) ? b_if.wr : a_if.wr;
            m_addr   <= pick(a_if.req, b_if.req, m_last) ? b_if.addr : a_if.addr;
            m_wdata  <= pick(a_if.req, b_if.req, m_last) ? b_if.wdata : a_if.wdata;
            m_active <= 1'b1;
            m_off    <= 0;
            n_grants <= n_grants + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ram_rst", ram_rst, m_init);
        chk("ram_we", ram_we, m_active && m_off == 1 && m_wr);
        chk("ram_re", ram_re, m_active && m_off == 1 && !m_wr);
        chk("we_and_re", ram_we && ram_re, 0);
        chk("a_ack", a_if.ack, m_active && m_off == 2 && !m_who);
        chk("b_ack", b_if.ack, m_active && m_off == 2 && m_who);
        chk("a_rdata", a_if.rdata, ref_rd[0]);
        chk("b_rdata", b_if.rdata, ref_rd[1]);
        if (m_active) chk("ram_addr", ram_addr, m_addr);
        if (exp_drive) chk("bus_write", ram_data, m_wdata);
        else if (!ram_re) chk("bus_released", ram_data, 0);
        n_acks += int'(a_if.ack) + int'(b_if.ack);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit who, input bit r, input bit wr, input logic [2:0] addr, input logic [15:0] d);
        if (who) begin
            b_if.req = r; b_if.wr = wr; b_if.addr = addr; b_if.wdata = d;
        end else begin
            a_if.req = r; a_if.wr = wr; a_if.addr = addr; a_if.wdata = d;
        end
    endtask

    task automatic do_op(input bit who, input bit wr, input logic [2:0] addr, input logic [15:0] d, input string nm);
        int n = 0;
        bit got = 0;
        set_req(who, 1'b1, wr, addr, d);
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = who ? b_if.ack : a_if.ack;
        end
        chk({nm, "_latency"}, n, 3);
        tick();
        set_req(who, 1'b0, wr, addr, d);
    endtask

    int e, k;
    int at [4];
    bit who_q [4];
    int a_at, b_at, g0, a0;

    initial begin
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        // reset hold and the one-cycle ram_rst tail
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_rst_hold", ram_rst, 1);
        chk("t1_acks", {a_if.ack, b_if.ack}, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_rst_tail", ram_rst, 1);
        tick();
        chk("t1_rst_done", ram_rst, 0);

        // A writes, B reads it back
        do_op(0, 1, 3'd3, 16'hBEEF, "t2_a_wr");
        do_op(1, 0, 3'd3, 16'h0000, "t2_b_rd");
        chk("t2_b_rdata", b_if.rdata, 16'hBEEF);
        chk("t2_a_rdata", a_if.rdata, 16'h0000);

        // both requesting from reset: strict alternation every 4 cycles
        rst = 1'b1;
        set_req(0, 1, 1, 3'd0, 16'h1111);
        set_req(1, 1, 1, 3'd5, 16'h2222);
        repeat (3) tick();
        rst = 1'b0;
        e = 0;
        k = 0;
        while (k < 4 && e < 40) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (a_if.ack || b_if.ack) begin
                who_q[k] = b_if.ack;
                at[k] = e;
                k++;
            end
        end
        chk("t3_ack_count", k, 4);
        chk("t3_order", {who_q[0], who_q[1], who_q[2], who_q[3]}, 4'b0101);
        chk("t3_first_ack", at[0], 4);
        for (int i = 1; i < 4; i++) chk("t3_spacing", at[i] - at[i-1], 4);
        tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        tick();

        // simultaneous A write / B read to the same address; A still requesting after its ack
        set_req(0, 1, 1, 3'd7, 16'h1234);
        set_req(1, 1, 0, 3'd7, 16'h0000);
        e = 0;
        a_at = 0;
        b_at = 0;
        while (b_at == 0 && e < 30) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (a_if.ack && a_at == 0) a_at = e;
            if (b_if.ack) b_at = e;
        end
        chk("t4_a_first", a_at, 3);
        chk("t4_b_second", b_at, 7);
        chk("t4_b_rdata", b_if.rdata, 16'h1234);
        tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        tick();

        // reset during the strobe of a write
        do_op(0, 1, 3'd1, 16'h5A5A, "t5_pre_wr");
        set_req(0, 1, 1, 3'd1, 16'hFFFF);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t5_strobe_we", ram_we, 1);
        set_req(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("t5_async_we", ram_we, 0);
        chk("t5_async_rst", ram_rst, 1);
        chk("t5_no_ack", a_if.ack, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        do_op(0, 1, 3'd2, 16'h7777, "t5_wr2");
        do_op(0, 0, 3'd2, 16'h0000, "t5_rd2");
        chk("t5_rd2_data", a_if.rdata, 16'h7777);
        do_op(0, 0, 3'd1, 16'h0000, "t5_rd1");
        chk("t5_cleared", a_if.rdata, 16'h0000);

        // random traffic; fields change freely after grant and req may drop early
        g0 = n_grants;
        a0 = n_acks;
        repeat (3000) begin
            tick();
            set_req(0, $urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 16'($urandom));
            set_req(1, $urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 16'($urandom));
        end
        tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (6) tick();
        chk("t6_one_ack_per_grant", n_acks - a0, n_grants - g0);
        chk("t6_traffic_seen", (n_grants - g0) > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
